// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: captures a pattern on start and shifts it out MSB first, repeating frames with idle gaps
module serial_pattern_tx #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       repeats,
    output logic             ready,
    output logic             y,
    output logic             y_valid,
    output logic             done,
    output logic [7:0]       frame_count
);
    localparam int BW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, hold_q, hold_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [3:0]       rep_q, rep_d, gap_q, gap_d;
    logic [7:0]       fc_q, fc_d;
    // Outputs decode only registered state, so they never follow the inputs combinationally
    assign ready       = state_q == IDLE;
    assign y_valid     = state_q == SHIFT;
    assign y           = state_q == SHIFT && sh_q[WIDTH-1];
    assign done        = state_q == DONE;
    assign frame_count = fc_q;
    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            hold_q  <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            fc_q    <= fc_d;
        end
    end
    // Next-state logic: capture on start, shift frames, insert gaps, pulse done
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        fc_d    = fc_q;
        case (state_q)
            IDLE: if (start) begin
                sh_d    = pattern;
                hold_d  = pattern;
                rep_d   = (repeats == 4'd0) ? 4'd1 : repeats;
                bit_d   = BW'(WIDTH - 1);
                state_d = SHIFT;
            end
            SHIFT: begin
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                bit_d = bit_q - 1'b1;
                if (bit_q == '0) begin
                    fc_d = fc_q + 8'd1;
                    if (rep_q > 4'd1) begin
                        rep_d = rep_q - 4'd1;
                        sh_d  = hold_q;
                        bit_d = BW'(WIDTH - 1);
                        if (GAP_CYCLES > 0) begin
                            gap_d   = 4'(GAP_CYCLES - 1);
                            state_d = GAP;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                gap_d   = gap_q - 4'd1;
                state_d = (gap_q == 4'd0) ? SHIFT : GAP;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: randomized and directed checks of two transmitters (gap 2 and gap 0) against a timeline model
module tb_serial_pattern_tx;
    localparam int W = 4;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [W-1:0] pattern = '0;
    logic [3:0] repeats = '0;
    logic ready[2], y[2], yv[2], done[2];
    logic [7:0] fc[2];
    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic busy_m[2] = '{1'b0, 1'b0};
    int t0_m[2] = '{0, 0};
    int rep_m[2] = '{1, 1};
    int gap_m[2] = '{2, 0};
    logic [W-1:0] pat_m[2] = '{'0, '0};
    logic [7:0] base_m[2] = '{8'd0, 8'd0};
    logic [31:0] ty[2], tv[2], td[2], tr[2];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .repeats(repeats),
        .ready(ready[0]), .y(y[0]), .y_valid(yv[0]), .done(done[0]), .frame_count(fc[0]));
    serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .repeats(repeats),
        .ready(ready[1]), .y(y[1]), .y_valid(yv[1]), .done(done[1]), .frame_count(fc[1]));

    // Expected {frame_count, ready, y, y_valid, done} in cycle c, from the transmission timeline:
    // frames of W bits every W+gap cycles, then a done cycle, then idle
    function automatic logic [11:0] exp_at(int d, int c);
        int k, p, l, r, n;
        logic [7:0] f_cnt;
        logic yy, vv, dd, rr;
        n = rep_m[d];
        p = W + gap_m[d];
        l = n * W + (n - 1) * gap_m[d];
        k = c - t0_m[d] - 1;
        f_cnt = base_m[d];
        rr = 1'b1; yy = 1'b0; vv = 1'b0; dd = 1'b0;
        if (busy_m[d]) begin
            for (int i = 0; i < n; i++) if (i * p + W <= k) f_cnt = f_cnt + 8'd1;
            if (k < l) begin
                rr = 1'b0;
                r = k % p;
                if (r < W) begin
                    vv = 1'b1;
                    yy = pat_m[d][W-1-r];
                end
            end else if (k == l) begin
                rr = 1'b0;
                dd = 1'b1;
            end
        end
        return {f_cnt, rr, yy, vv, dd};
    endfunction

    function automatic logic is_ready(int d, int c);
        logic [11:0] e;
        e = exp_at(d, c);
        return e[3];
    endfunction

    function automatic logic [7:0] fc_at(int d, int c);
        logic [11:0] e;
        e = exp_at(d, c);
        return e[11:4];
    endfunction

    // Model: record each accepted transmission
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= 0;
            busy_m <= '{1'b0, 1'b0};
            base_m <= '{8'd0, 8'd0};
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (is_ready(d, cyc) && start) begin
                    t0_m[d]   <= cyc;
                    pat_m[d]  <= pattern;
                    rep_m[d]  <= (repeats == 4'd0) ? 1 : int'(repeats);
                    base_m[d] <= fc_at(d, cyc);
                    busy_m[d] <= 1'b1;
                end
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(ready[0] && ready[1]) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("wait_idle timeout", {31'b0, ready[0] & ready[1]}, 32'd1);
    endtask

    task automatic trace(input logic [3:0] p, input logic [3:0] r, input int n);
        wait_idle();
        start = 1'b1;
        pattern = p;
        repeats = r;
        for (int d = 0; d < 2; d++) begin
            ty[d] = '0; tv[d] = '0; td[d] = '0; tr[d] = '0;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            pattern = 4'($urandom);
            repeats = 4'($urandom);
            for (int d = 0; d < 2; d++) begin
                ty[d] = {ty[d][30:0], y[d]};
                tv[d] = {tv[d][30:0], yv[d]};
                td[d] = {td[d][30:0], done[d]};
                tr[d] = {tr[d][30:0], ready[d]};
            end
        end
    endtask

    initial begin
        int cnt;
        fork
            forever begin
                @(negedge clk);
                for (int d = 0; d < 2; d++)
                    check($sformatf("dut%0d outputs", d),
                          {20'b0, fc[d], ready[d], y[d], yv[d], done[d]}, {20'b0, exp_at(d, cyc)});
            end
        join_none
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset state dut0", {fc[0], ready[0], y[0], yv[0], done[0]}, 12'h008);
        check("reset state dut1", {fc[1], ready[1], y[1], yv[1], done[1]}, 12'h008);
        // single frame 1000
        trace(4'b1000, 4'd1, 6);
        check("t1 y", ty[0], 32'b100000);
        check("t1 y_valid", tv[0], 32'b111100);
        check("t1 done", td[0], 32'b000010);
        check("t1 ready", tr[0], 32'b000001);
        check("t1 frame_count", {24'b0, fc[0]}, 32'd1);
        // three frames 1011 with gaps (dut0) and back to back (dut1)
        trace(4'b1011, 4'd3, 18);
        check("t2 y gap2", ty[0], 32'b101100101100101100);
        check("t2 y_valid gap2", tv[0], 32'b111100111100111100);
        check("t2 done gap2", td[0], 32'b000000000000000010);
        check("t2 y gap0", ty[1], 32'b101110111011000000);
        check("t2 y_valid gap0", tv[1], 32'b111111111111000000);
        check("t2 done gap0", td[1], 32'b000000000000100000);
        check("t2 frame_count", {24'b0, fc[0]}, 32'd4);
        // repeat 0 sends one frame
        trace(4'b0110, 4'd0, 6);
        check("t3 y", ty[0], 32'b011000);
        check("t3 y_valid", tv[0], 32'b111100);
        check("t3 done", td[0], 32'b000010);
        check("t3 frame_count", {24'b0, fc[1]}, 32'd5);
        // gap 0, two frames of 1000
        trace(4'b1000, 4'd2, 10);
        check("t4 y gap0", ty[1], 32'b1000100000);
        check("t4 y_valid gap0", tv[1], 32'b1111111100);
        check("t4 done gap0", td[1], 32'b0000000010);
        check("t4 frame_count gap0", {24'b0, fc[1]}, 32'd7);
        // ignored start/pattern mid-frame, then reset after the second bit
        wait_idle();
        start = 1'b1; pattern = 4'b1111; repeats = 4'd1;
        @(negedge clk);
        check("t5 bit1", {31'b0, y[0]}, 32'd1);
        start = 1'b1; pattern = 4'b0000; repeats = 4'd5;
        @(negedge clk);
        check("t5 bit2", {30'b0, y[0], yv[0]}, 32'b11);
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t5 async reset dut0", {fc[0], ready[0], y[0], yv[0], done[0]}, 12'h008);
        check("t5 async reset dut1", {fc[1], ready[1], y[1], yv[1], done[1]}, 12'h008);
        @(negedge clk);
        #2 reset = 1'b0;
        // 256 single frames with start held high
        @(negedge clk);
        repeats = 4'd1;
        start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2000 && cnt < 256; i++) begin
            @(negedge clk);
            if (done[0]) begin
                cnt++;
                if (cnt == 255) check("fc after 255 frames", {24'b0, fc[0]}, 32'd255);
                if (cnt == 256) check("fc wrap after 256 frames", {24'b0, fc[0]}, 32'd0);
            end
            pattern = 4'($urandom);
        end
        if (cnt < 256) check("256 frames timeout", cnt, 32'd256);
        start = 1'b0;
        // random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            pattern = 4'($urandom);
            repeats = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
